// File: rtl/wb_mem_responder.sv
// Wishbone responder modelling main DRAM as an on-chip word array with programmable wait states.
// Define WB_MEM_BURST_EN to enable the single-cycle incrementing-burst path (cti=010, bte=00).
module wb_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          ADDR_W      = 20,
    parameter int          WAIT_STATES = 2
) (
    input  logic        clk_25m,
    input  logic        reset_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic [2:0]  i_wb_cti,
    input  logic [1:0]  i_wb_bte,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_busy
);
    localparam int          IDX_W    = ADDR_W - 2;
    localparam int          DEPTH    = 2 ** IDX_W;
    localparam logic [31:0] WIN_MASK = ~((32'd1 << ADDR_W) - 32'd1);
    localparam logic [3:0]  WS_INIT  = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

`ifdef WB_MEM_BURST_EN
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACK, S_RECOV, S_BURST} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACK, S_RECOV} state_t;
`endif

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               we_q, we_d;
    logic [31:0]        wdat_q, wdat_d;
    logic [3:0]         sel_q, sel_d;

    logic               hit;
    logic               req;
    logic               rd_en;
    logic [IDX_W-1:0]   rd_idx;
    logic               wr_en;
    logic [31:0]        wr_data;
    logic [3:0]         wr_sel;
    logic               unused_ok;

    assign hit       = (i_wb_adr & WIN_MASK) == BASE_ADDR;
    assign req       = i_wb_cyc & i_wb_stb & hit;
    assign unused_ok = ^{i_wb_adr[1:0], i_wb_cti, i_wb_bte};

    always_ff @(posedge clk_25m) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdat_q  <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
        end
    end

    // Read port is issued on the edge entering an ack cycle so o_wb_dat is valid during it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        rd_en   = 1'b0;
        rd_idx  = idx_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    idx_d  = i_wb_adr[ADDR_W-1:2];
                    we_d   = i_wb_we;
                    wdat_d = i_wb_dat;
                    sel_d  = i_wb_sel;
                    cnt_d  = WS_INIT;
                    if (WAIT_STATES == 0) begin
                        state_d = S_ACK;
                        rd_en   = !i_wb_we;
                        rd_idx  = i_wb_adr[ADDR_W-1:2];
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!(i_wb_cyc && i_wb_stb)) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_ACK;
                    rd_en   = !we_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_RECOV;
`ifdef WB_MEM_BURST_EN
                if (i_wb_cyc && i_wb_stb && i_wb_cti == 3'b010 && i_wb_bte == 2'b00) begin
                    state_d = S_BURST;
                    idx_d   = idx_q + 1'b1;
                    rd_en   = !we_q;
                    rd_idx  = idx_q + 1'b1;
                end
`endif
            end
            S_RECOV: begin
                state_d = S_IDLE;
            end
`ifdef WB_MEM_BURST_EN
            S_BURST: begin
                if (!i_wb_cyc) begin
                    state_d = S_IDLE;
                end else if (i_wb_stb) begin
                    if (i_wb_cti == 3'b111) begin
                        state_d = S_RECOV;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        rd_en  = !we_q;
                        rd_idx = idx_q + 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        o_wb_ack = 1'b0;
        o_busy   = (state_q != S_IDLE);
        wr_en    = 1'b0;
        wr_data  = wdat_q;
        wr_sel   = sel_q;
        case (state_q)
            S_ACK: begin
                o_wb_ack = 1'b1;
                wr_en    = we_q;
            end
`ifdef WB_MEM_BURST_EN
            S_BURST: begin
                o_wb_ack = i_wb_cyc & i_wb_stb;
                wr_en    = we_q & i_wb_cyc & i_wb_stb;
                wr_data  = i_wb_dat;
                wr_sel   = i_wb_sel;
            end
`endif
            default: begin
                o_wb_ack = 1'b0;
            end
        endcase
    end

    // One byte-wide array per lane keeps lane enables independent without read-modify-write.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem_q [DEPTH];
        logic [7:0] rd_q;

        always_ff @(posedge clk_25m) begin
            if (wr_en && reset_n && wr_sel[gi]) begin
                mem_q[idx_q] <= wr_data[8*gi +: 8];
            end
        end

        always_ff @(posedge clk_25m) begin
            if (!reset_n) begin
                rd_q <= '0;
            end else if (rd_en) begin
                rd_q <= mem_q[rd_idx];
            end
        end

        assign o_wb_dat[8*gi +: 8] = rd_q;
    end

endmodule

// File: tb/tb_wb_mem_responder.sv
// Self-checking bench for wb_mem_responder: classic timing, byte lanes, abort, reset, burst/back-to-back, decode.
module tb_wb_mem_responder;
    localparam int WS = 2;
    localparam int AW = 20;
`ifdef WB_MEM_BURST_EN
    localparam int BEAT_GAP = 1;
`else
    localparam int BEAT_GAP = WS + 3;
`endif

    logic        clk_25m;
    logic        reset_n;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_w;
    logic [3:0]  wb_sel;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic [31:0] wb_dat_r;
    logic        wb_ack;
    logic        busy;

    int          tests_run;
    int          tests_failed;
    int          edge_cnt;
    logic [31:0] exp_q[$];
    logic [31:0] got_dat[$];
    int          got_edge[$];

    wb_mem_responder #(
        .BASE_ADDR  (32'h0000_0000),
        .ADDR_W     (AW),
        .WAIT_STATES(WS)
    ) dut (
        .clk_25m (clk_25m),
        .reset_n (reset_n),
        .i_wb_cyc(wb_cyc),
        .i_wb_stb(wb_stb),
        .i_wb_we (wb_we),
        .i_wb_adr(wb_adr),
        .i_wb_dat(wb_dat_w),
        .i_wb_sel(wb_sel),
        .i_wb_cti(wb_cti),
        .i_wb_bte(wb_bte),
        .o_wb_dat(wb_dat_r),
        .o_wb_ack(wb_ack),
        .o_busy  (busy)
    );

    initial clk_25m = 1'b0;
    always #5 clk_25m = ~clk_25m;

    initial edge_cnt = 0;
    always @(posedge clk_25m) edge_cnt <= edge_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1);
    end

    // Classic single transfer; lat counts cycles from the stb-sampling edge, inclusive.
    task automatic bus_xfer(input logic we_v, input logic [31:0] adr_v, input logic [31:0] dat_v,
                            input logic [3:0] sel_v, input int max_wait,
                            output logic acked, output logic [31:0] rdata, output int lat);
        int req_edge;
        @(posedge clk_25m); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we_v; wb_adr = adr_v;
        wb_dat_w = dat_v; wb_sel = sel_v; wb_cti = 3'b000; wb_bte = 2'b00;
        req_edge = edge_cnt + 1;
        acked = 1'b0; rdata = '0; lat = -1;
        for (int i = 0; i < max_wait && !acked; i++) begin
            @(negedge clk_25m);
            if (wb_ack === 1'b1) begin
                acked = 1'b1;
                rdata = wb_dat_r;
                lat   = edge_cnt - req_edge + 1;
            end
        end
        @(posedge clk_25m); #1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        $display("[TB] %s adr=%h wdat=%h sel=%b ack=%0d lat=%0d rdat=%h",
                 we_v ? "WR" : "RD", adr_v, dat_v, sel_v, acked, lat, rdata);
    endtask

    // Read beats with cti 010..010,111; cyc/stb held throughout, next beat driven after each ack.
    task automatic run_beats(input logic [31:0] start, input int n, output int first_req);
        int   t;
        logic seen;
        got_dat.delete();
        got_edge.delete();
        @(posedge clk_25m); #1;
        first_req = edge_cnt + 1;
        for (int k = 0; k < n; k++) begin
            wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 4'hF; wb_bte = 2'b00;
            wb_adr = start + 32'(4 * k);
            wb_cti = (k == n - 1) ? 3'b111 : 3'b010;
            t = 0; seen = 1'b0;
            while (!seen && t < 40) begin
                @(negedge clk_25m);
                t++;
                if (wb_ack === 1'b1) begin
                    seen = 1'b1;
                    got_dat.push_back(wb_dat_r);
                    got_edge.push_back(edge_cnt);
                end
            end
            @(posedge clk_25m); #1;
            $display("[TB] BEAT %0d adr=%h cti=%b ack=%0d rdat=%h", k, start + 32'(4 * k),
                     (k == n - 1) ? 3'b111 : 3'b010, seen, seen ? got_dat[got_dat.size()-1] : 32'h0);
            if (!seen) break;
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_cti = 3'b000;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk_25m);
        @(negedge clk_25m);
        tests_run++;
        if (wb_ack !== 1'b0) begin tests_failed++; $display("FAIL reset_ack got=%b exp=0", wb_ack); end
        tests_run++;
        if (wb_dat_r !== 32'h0) begin tests_failed++; $display("FAIL reset_dat got=%h exp=00000000", wb_dat_r); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
        @(posedge clk_25m); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_classic();
        logic        ok;
        logic [31:0] rd;
        logic [31:0] exp;
        int          lat;
        bus_xfer(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 20, ok, rd, lat);
        tests_run++;
        if (ok !== 1'b1 || lat != WS + 1) begin
            tests_failed++; $display("FAIL wr_latency got ack=%b lat=%0d exp ack=1 lat=%0d", ok, lat, WS + 1);
        end
        tests_run++;
        if (rd !== 32'h0) begin tests_failed++; $display("FAIL wr_keeps_dat got=%h exp=00000000", rd); end
        exp_q.push_back(32'hDEADBEEF);
        bus_xfer(1'b0, 32'h100, 32'h0, 4'hF, 20, ok, rd, lat);
        tests_run++;
        if (ok !== 1'b1 || lat != WS + 1) begin
            tests_failed++; $display("FAIL rd_latency got ack=%b lat=%0d exp ack=1 lat=%0d", ok, lat, WS + 1);
        end
        exp = exp_q.pop_front();
        tests_run++;
        if (rd !== exp) begin tests_failed++; $display("FAIL rd_data got=%h exp=%h", rd, exp); end
        repeat (3) @(negedge clk_25m);
        tests_run++;
        if (wb_dat_r !== 32'hDEADBEEF || wb_ack !== 1'b0) begin
            tests_failed++; $display("FAIL dat_hold got dat=%h ack=%b exp dat=deadbeef ack=0", wb_dat_r, wb_ack);
        end
        exp_q.push_back(32'hDEADBEEF);
        bus_xfer(1'b0, 32'h103, 32'h0, 4'hF, 20, ok, rd, lat);
        exp = exp_q.pop_front();
        tests_run++;
        if (ok !== 1'b1 || rd !== exp) begin
            tests_failed++; $display("FAIL rd_low_bits got ack=%b dat=%h exp ack=1 dat=%h", ok, rd, exp);
        end
    endtask

    task automatic test_byte_lanes();
        logic        ok;
        logic [31:0] rd;
        logic [31:0] exp;
        int          lat;
        bus_xfer(1'b1, 32'h10, 32'h11223344, 4'hF, 20, ok, rd, lat);
        bus_xfer(1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, 20, ok, rd, lat);
        exp_q.push_back(32'h11BB33DD);
        bus_xfer(1'b0, 32'h10, 32'h0, 4'hF, 20, ok, rd, lat);
        exp = exp_q.pop_front();
        tests_run++;
        if (ok !== 1'b1 || rd !== exp) begin
            tests_failed++; $display("FAIL byte_lanes got ack=%b dat=%h exp ack=1 dat=%h", ok, rd, exp);
        end
        bus_xfer(1'b1, 32'h10, 32'h00EE0000, 4'b0100, 20, ok, rd, lat);
        exp_q.push_back(32'h11EE33DD);
        bus_xfer(1'b0, 32'h10, 32'h0, 4'hF, 20, ok, rd, lat);
        exp = exp_q.pop_front();
        tests_run++;
        if (ok !== 1'b1 || rd !== exp) begin
            tests_failed++; $display("FAIL byte_lane2 got ack=%b dat=%h exp ack=1 dat=%h", ok, rd, exp);
        end
    endtask

    task automatic test_abort();
        logic        ok;
        logic [31:0] rd;
        logic [31:0] exp;
        int          lat;
        int          acks;
        logic        busy_seen;
        bus_xfer(1'b1, 32'h30, 32'h0F0F0F0F, 4'hF, 20, ok, rd, lat);
        @(posedge clk_25m); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 32'h30; wb_dat_w = 32'hFFFFFFFF; wb_sel = 4'hF;
        @(posedge clk_25m); #1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        acks = 0; busy_seen = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_25m);
            if (wb_ack === 1'b1) acks++;
            if (i == 1) busy_seen = busy;
        end
        $display("[TB] ABORT adr=00000030 acks=%0d busy_after_2=%b", acks, busy_seen);
        tests_run++;
        if (acks != 0) begin tests_failed++; $display("FAIL abort_ack got=%0d exp=0", acks); end
        tests_run++;
        if (busy_seen !== 1'b0) begin tests_failed++; $display("FAIL abort_busy got=%b exp=0", busy_seen); end
        exp_q.push_back(32'h0F0F0F0F);
        bus_xfer(1'b0, 32'h30, 32'h0, 4'hF, 20, ok, rd, lat);
        exp = exp_q.pop_front();
        tests_run++;
        if (ok !== 1'b1 || rd !== exp) begin
            tests_failed++; $display("FAIL abort_data got ack=%b dat=%h exp ack=1 dat=%h", ok, rd, exp);
        end
    endtask

    task automatic test_reset_mid();
        logic        ok;
        logic [31:0] rd;
        logic [31:0] exp;
        int          lat;
        int          acks;
        bus_xfer(1'b1, 32'h20, 32'h12345678, 4'hF, 20, ok, rd, lat);
        bus_xfer(1'b0, 32'h20, 32'h0, 4'hF, 20, ok, rd, lat);
        @(posedge clk_25m); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 32'h20; wb_dat_w = 32'h00000055; wb_sel = 4'hF;
        acks = 0;
        @(negedge clk_25m);
        if (wb_ack === 1'b1) acks++;
        @(posedge clk_25m); #1;
        reset_n = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(negedge clk_25m);
        if (wb_ack === 1'b1) acks++;
        @(posedge clk_25m); #1;
        reset_n = 1'b1;
        @(negedge clk_25m);
        tests_run++;
        if (wb_dat_r !== 32'h0 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL rstmid_outputs got dat=%h busy=%b exp dat=00000000 busy=0", wb_dat_r, busy);
        end
        for (int i = 0; i < 8; i++) begin
            if (wb_ack === 1'b1) acks++;
            @(negedge clk_25m);
        end
        $display("[TB] RESET-MID adr=00000020 acks=%0d", acks);
        tests_run++;
        if (acks != 0) begin tests_failed++; $display("FAIL rstmid_ack got=%0d exp=0", acks); end
        exp_q.push_back(32'h12345678);
        bus_xfer(1'b0, 32'h20, 32'h0, 4'hF, 20, ok, rd, lat);
        exp = exp_q.pop_front();
        tests_run++;
        if (ok !== 1'b1 || rd !== exp) begin
            tests_failed++; $display("FAIL rstmid_data got ack=%b dat=%h exp ack=1 dat=%h", ok, rd, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic        ok;
        logic [31:0] rd;
        logic [31:0] exp;
        int          lat;
        int          first_req;
        for (int k = 0; k < 4; k++) begin
            bus_xfer(1'b1, 32'h40 + 32'(4 * k), 32'hB0000000 + 32'(k * 32'h0101), 4'hF, 20, ok, rd, lat);
            exp_q.push_back(32'hB0000000 + 32'(k * 32'h0101));
        end
        run_beats(32'h40, 4, first_req);
        tests_run++;
        if (got_dat.size() != 4) begin
            tests_failed++; $display("FAIL beats_count got=%0d exp=4", got_dat.size());
        end
        for (int k = 0; k < 4; k++) begin
            exp = exp_q.pop_front();
            if (k < got_dat.size()) begin
                tests_run++;
                if (got_dat[k] !== exp) begin
                    tests_failed++; $display("FAIL beat%0d_data got=%h exp=%h", k, got_dat[k], exp);
                end
            end
        end
        if (got_edge.size() > 0) begin
            tests_run++;
            if (got_edge[0] - first_req + 1 != WS + 1) begin
                tests_failed++; $display("FAIL beat0_latency got=%0d exp=%0d", got_edge[0] - first_req + 1, WS + 1);
            end
        end
        for (int k = 1; k < got_edge.size(); k++) begin
            tests_run++;
            if (got_edge[k] - got_edge[k-1] != BEAT_GAP) begin
                tests_failed++; $display("FAIL beat%0d_gap got=%0d exp=%0d", k, got_edge[k] - got_edge[k-1], BEAT_GAP);
            end
        end
        repeat (3) @(negedge clk_25m);
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL beats_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_decode_wrap();
        logic        ok;
        logic [31:0] rd;
        logic [31:0] exp;
        int          lat;
        logic [31:0] top;
        top = (32'd1 << AW) - 32'd4;
        bus_xfer(1'b1, top, 32'h70707070, 4'hF, 20, ok, rd, lat);
        bus_xfer(1'b1, 32'h0, 32'h0BADF00D, 4'hF, 20, ok, rd, lat);
        bus_xfer(1'b1, 32'd1 << AW, 32'hFFFFFFFF, 4'hF, 20, ok, rd, lat);
        tests_run++;
        if (ok !== 1'b0) begin tests_failed++; $display("FAIL oow_write_ack got=%b exp=0", ok); end
        bus_xfer(1'b0, 32'd1 << AW, 32'h0, 4'hF, 20, ok, rd, lat);
        tests_run++;
        if (ok !== 1'b0) begin tests_failed++; $display("FAIL oow_read_ack got=%b exp=0", ok); end
        exp_q.push_back(32'h70707070);
        bus_xfer(1'b0, top, 32'h0, 4'hF, 20, ok, rd, lat);
        exp = exp_q.pop_front();
        tests_run++;
        if (ok !== 1'b1 || rd !== exp) begin
            tests_failed++; $display("FAIL top_word got ack=%b dat=%h exp ack=1 dat=%h", ok, rd, exp);
        end
        exp_q.push_back(32'h0BADF00D);
        bus_xfer(1'b0, 32'h0, 32'h0, 4'hF, 20, ok, rd, lat);
        exp = exp_q.pop_front();
        tests_run++;
        if (ok !== 1'b1 || rd !== exp) begin
            tests_failed++; $display("FAIL word0_no_alias got ack=%b dat=%h exp ack=1 dat=%h", ok, rd, exp);
        end
`ifdef WB_MEM_BURST_EN
        begin
            int first_req;
            exp_q.push_back(32'h70707070);
            exp_q.push_back(32'h0BADF00D);
            run_beats(top, 2, first_req);
            tests_run++;
            if (got_dat.size() != 2) begin
                tests_failed++; $display("FAIL wrap_count got=%0d exp=2", got_dat.size());
            end
            for (int k = 0; k < 2; k++) begin
                exp = exp_q.pop_front();
                if (k < got_dat.size()) begin
                    tests_run++;
                    if (got_dat[k] !== exp) begin
                        tests_failed++; $display("FAIL wrap_beat%0d got=%h exp=%h", k, got_dat[k], exp);
                    end
                end
            end
        end
`endif
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        reset_n = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_adr = '0;
        wb_dat_w = '0; wb_sel = '0; wb_cti = '0; wb_bte = '0;
        test_reset();
        test_classic();
        test_byte_lanes();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_decode_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
